// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int ILEN       = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [ILEN-1:0]       instr;
  } fetch_entry_t;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push, head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  fetch_entry_t            push_data,
  input  logic                    pop,
  input  logic                    flush,
  output fetch_entry_t            head,
  output logic [occ_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_w(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == OW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + OW'(do_push) - OW'(do_pop);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: issues credit-limited in-order fetches and buffers
// responses for decode, discarding responses made stale by redirects.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                 XLEN     = FETCH_XLEN,
  parameter int                 DEPTH    = 4,
  parameter int                 MAX_OUT  = 2,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_data,
  output logic [XLEN-1:0]         inst_pc,
  output logic [occ_w(DEPTH)-1:0] occupancy
);

  localparam int OW = occ_w(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = OW + CW;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   live_cnt;
  logic            req_pending;
  logic            can_issue;
  logic            req_hs;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            inst_pop;
  logic            fifo_push;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;

  // Stale responses still in flight will never take a queue slot.
  assign live_cnt  = inflight - drop_cnt;
  assign can_issue = !halt
                  && (inflight < CW'(MAX_OUT))
                  && ((SW'(occupancy) + SW'(live_cnt)) < SW'(DEPTH));

  // A raised request is held through halt; only a redirect withdraws it.
  assign imem_req_valid = reset && !redirect_valid && (req_pending || can_issue);
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_data  = fifo_head.instr;
  assign inst_pc    = XLEN'(fifo_head.pc);

  assign fifo_push = rsp_keep && (!fifo_full || inst_pop);
  assign fifo_in   = '{pc: FETCH_XLEN'(rsp_pc), instr: imem_rsp_data};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      inflight    <= '0;
      drop_cnt    <= '0;
      req_pending <= 1'b0;
    end else if (redirect_valid) begin
      // Everything still outstanding is stale; a response arriving now is discarded too.
      fetch_pc    <= redirect_pc;
      rsp_pc      <= redirect_pc;
      inflight    <= inflight - CW'(imem_rsp_valid);
      drop_cnt    <= inflight - CW'(imem_rsp_valid);
      req_pending <= 1'b0;
    end else begin
      if (req_hs)   fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      inflight    <= inflight + CW'(req_hs) - CW'(imem_rsp_valid);
      req_pending <= imem_req_valid && !imem_req_ready;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of the fetch stream and an in-order memory model.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;

  fetch_queue_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          due;
  } req_t;

  // Model state: outstanding memory requests and the expected queue contents.
  req_t        out_q[$];
  logic [31:0] ent_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  bit          m_pending = 1'b0;
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];

  // Stimulus policy.
  int          ready_pct = 100;
  int          pop_pct   = 100;
  int          rsp_pct   = 100;
  int          lat_extra = 0;
  bit          halt_q    = 1'b0;
  bit          redir_req = 1'b0;
  logic [31:0] redir_target = '0;
  bit          force_rsp = 1'b0;
  int          cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic policy(input int rdy, input int pp, input int rp, input int lat, input bit h);
    ready_pct = rdy;
    pop_pct   = pp;
    rsp_pct   = rp;
    lat_extra = lat;
    halt_q    = h;
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model.
  task automatic step();
    int   live;
    bit   pred_req, pred_inst, hs, pop, rsp_now;
    req_t r;
    @(negedge clk);
    cyc++;
    reset          = 1'b1;
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 1'b0;
    halt           = halt_q;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < pop_pct);
    rsp_now = (out_q.size() > 0) && (out_q[0].due <= cyc) &&
              (force_rsp || ($urandom_range(99) < rsp_pct));
    force_rsp      = 1'b0;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(out_q[0].pc) : $urandom;
    #1;
    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    pred_req  = !redirect_valid &&
                (m_pending || (!halt && out_q.size() < MAX_OUT && ent_q.size() + live < DEPTH));
    pred_inst = (ent_q.size() > 0) && !redirect_valid;
    check("req_valid", imem_req_valid, pred_req);
    if (pred_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("occupancy", occupancy, ent_q.size());
    check("inst_valid", inst_valid, pred_inst);
    if (ent_q.size() > 0) begin
      check("inst_pc", inst_pc, ent_q[0]);
      check("inst_data", inst_data, mem_word(ent_q[0]));
    end
    hs  = pred_req && imem_req_ready;
    pop = pred_inst && inst_ready;
    if (hs)  hs_log.push_back(m_fetch_pc);
    if (pop) pop_log.push_back(ent_q[0]);
    r = '{pc: '0, stale: 1'b1, due: 0};
    if (rsp_now) r = out_q.pop_front();
    if (redirect_valid) begin
      ent_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
      m_pending  = 1'b0;
    end else begin
      if (pop) void'(ent_q.pop_front());
      if (rsp_now && !r.stale) ent_q.push_back(r.pc);
      if (hs) begin
        out_q.push_back('{pc: m_fetch_pc, stale: 1'b0, due: cyc + 1 + $urandom_range(lat_extra)});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_pending = pred_req && !hs;
    end
  endtask

  // Assert reset mid-cycle, check outputs clear at once and that responses are ignored.
  // Reset is released by the next step().
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_occupancy", occupancy, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    repeat (2) begin
      @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      #1;
      check("rst_hold_occ", occupancy, 0);
      check("rst_hold_req", imem_req_valid, 1'b0);
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    ent_q.delete();
    out_q.delete();
    m_fetch_pc = RESET_PC;
    m_pending  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with single-cycle memory.
    policy(100, 100, 100, 0, 1'b0);
    apply_reset();
    hs_log.delete();
    pop_log.delete();
    step();
    check("a_first_addr", imem_req_addr, RESET_PC);
    repeat (13) step();
    check("a_hs_count", hs_log.size() >= 3, 1'b1);
    check("a_pop_count", pop_log.size() >= 3, 1'b1);
    if (hs_log.size() >= 3 && pop_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("a_req_seq", hs_log[i], 32'(4 * i));
        check("a_pc_seq", pop_log[i], 32'(4 * i));
      end
    end

    // Decode stalled: credit stops at DEPTH, one pop frees one request.
    policy(100, 0, 100, 0, 1'b0);
    apply_reset();
    hs_log.delete();
    repeat (12) step();
    check("b_hs_count", hs_log.size(), 4);
    check("b_req_idle", imem_req_valid, 1'b0);
    check("b_occ_full", occupancy, 4);
    pop_pct = 100;
    step();
    pop_pct = 0;
    repeat (8) step();
    check("b_hs_after_pop", hs_log.size(), 5);

    // Redirect with two requests outstanding.
    policy(100, 100, 0, 0, 1'b0);
    apply_reset();
    hs_log.delete();
    redir_req = 1'b1;
    redir_target = 32'h10;
    step();
    for (int i = 0; i < 10 && hs_log.size() < 2; i++) step();
    check("c_hs_count", hs_log.size(), 2);
    if (hs_log.size() >= 2) begin
      check("c_addr0", hs_log[0], 32'h10);
      check("c_addr1", hs_log[1], 32'h14);
    end
    pop_log.delete();
    redir_req = 1'b1;
    redir_target = 32'h100;
    step();
    rsp_pct = 100;
    step();
    check("c_occ_flushed", occupancy, 0);
    repeat (10) step();
    check("c_popped", pop_log.size() > 0, 1'b1);
    if (pop_log.size() > 0) check("c_first_pc", pop_log[0], 32'h100);

    // Request held while memory stalls and halt rises.
    policy(0, 100, 100, 0, 1'b0);
    apply_reset();
    hs_log.delete();
    step();
    check("d_req_raised", imem_req_valid, 1'b1);
    halt_q = 1'b1;
    repeat (5) begin
      step();
      check("d_req_hold", imem_req_valid, 1'b1);
      check("d_addr_stable", imem_req_addr, RESET_PC);
    end
    ready_pct = 100;
    step();
    repeat (6) step();
    check("d_single_hs", hs_log.size(), 1);
    check("d_req_quiet", imem_req_valid, 1'b0);

    // Response coinciding with redirect while two are in flight.
    policy(100, 100, 0, 0, 1'b0);
    apply_reset();
    hs_log.delete();
    for (int i = 0; i < 10 && hs_log.size() < 2; i++) step();
    check("e_hs_count", hs_log.size(), 2);
    pop_log.delete();
    force_rsp = 1'b1;
    redir_req = 1'b1;
    redir_target = 32'h200;
    step();
    rsp_pct = 100;
    repeat (10) step();
    check("e_popped", pop_log.size() > 0, 1'b1);
    if (pop_log.size() > 0) check("e_first_pc", pop_log[0], 32'h200);

    // Reset with requests in flight and entries queued.
    policy(100, 0, 100, 0, 1'b0);
    apply_reset();
    repeat (3) step();
    rsp_pct = 0;
    repeat (3) step();
    check("f_pre_occ", occupancy != 0, 1'b1);
    apply_reset();
    step();
    check("f_req_valid", imem_req_valid, 1'b1);
    check("f_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic with redirects, halts, a wrap-around target and a mid-run reset.
    for (int seg = 0; seg < 15; seg++) begin
      policy($urandom_range(30, 100), $urandom_range(0, 100), $urandom_range(20, 100),
             $urandom_range(0, 3), ($urandom_range(4) == 0));
      if (seg == 7) apply_reset();
      if (seg == 3) begin
        redir_req = 1'b1;
        redir_target = 32'hFFFF_FFF8;
      end
      repeat (200) begin
        if (!redir_req && $urandom_range(99) < 3) begin
          redir_req = 1'b1;
          redir_target = $urandom & 32'hFFFF_FFFC;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, address/PC width.
- DEPTH, 4, instruction queue entries; power of two, >= 2.
- MAX_OUT, 2, maximum outstanding memory requests; 1..DEPTH.
- RESET_PC, 0, first fetch address after reset.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low.
- halt, in, 1, stop issuing new fetches (program done).
- redirect_valid, in, 1, branch/jump redirect strobe.
- redirect_pc, in, XLEN, redirect target.
- imem_req_valid, out, 1, fetch request valid.
- imem_req_ready, in, 1, memory/L1 accepts request.
- imem_req_addr, out, XLEN, fetch address.
- imem_rsp_valid, in, 1, response strobe; always accepted.
- imem_rsp_data, in, 32, fetched instruction.
- inst_valid, out, 1, queue head valid.
- inst_ready, in, 1, decode consumes head.
- inst_data, out, 32, head instruction.
- inst_pc, out, XLEN, head PC.
- occupancy, out, clog2(DEPTH+1), queued entries.

Function
REQ-003 A request handshake SHALL occur when imem_req_valid and imem_req_ready are both 1; the unit SHALL then increment fetch_pc by 4, modulo 2^XLEN.

REQ-004 A new request SHALL be raised only when all of the following hold:
- halt=0;
- redirect_valid=0;
- inflight < MAX_OUT;
- occupancy + inflight < DEPTH.

REQ-005 Once raised, imem_req_valid and imem_req_addr SHALL stay stable until the handshake; only redirect_valid may withdraw the request, and a later halt SHALL NOT withdraw it.

REQ-006 Responses SHALL return in request order, at the earliest one cycle after their handshake. Each kept response SHALL:
- be written to the queue tail with pc = rsp_pc;
- increment rsp_pc by 4.

REQ-007 inst_valid SHALL be 1 exactly when occupancy > 0 and redirect_valid = 0. inst_data and inst_pc SHALL come from the registered head, with no response-to-output bypass, so the fetch-to-inst_valid latency is 1 cycle after the response.

REQ-008 A pop SHALL occur on inst_valid && inst_ready. A push and a pop in the same cycle SHALL leave occupancy unchanged. The queue SHALL never overflow, because the credit rule in REQ-004 guarantees a free slot for every in-flight response.

REQ-009 In a cycle with redirect_valid=1, the next state SHALL be:
- queue flushed (occupancy=0);
- fetch_pc and rsp_pc set to redirect_pc;
- drop_cnt set to the outstanding responses not yet returned, excluding any response arriving in this same cycle, which is itself discarded.

REQ-010 While drop_cnt > 0, each response SHALL be discarded and drop_cnt decremented. Responses discarded this way SHALL NOT count toward the REQ-004 occupancy + inflight credit.

REQ-011 Back-to-back redirects SHALL each take effect, with the last one winning. A redirect arriving while drop_cnt > 0 SHALL accumulate correctly, counting all outstanding stale requests.

REQ-012 The inflight counter SHALL:
- increment on each handshake;
- decrement on each response, whether kept or dropped;
- be unchanged when a handshake and a response coincide.

REQ-013 halt SHALL NOT flush the queue: queued instructions still drain, and in-flight responses are still stored.

Reset
REQ-014 While reset=0, asynchronously:
- fetch_pc = rsp_pc = RESET_PC;
- occupancy, inflight and drop_cnt = 0;
- imem_req_valid = 0 and inst_valid = 0;
- inst_data and inst_pc = 0.

REQ-015 A reset asserted mid-operation SHALL abandon all outstanding requests. Responses arriving while reset is low SHALL be ignored.

REQ-016 The first request (addr = RESET_PC) SHALL be raised in the first cycle after reset deasserts, if halt=0.

Structure
REQ-017 Package fetch_pkg SHALL hold:
- ILEN = 32;
- the struct fetch_entry_t {pc[XLEN], instr[ILEN]};
- the clog2-based width helper for occupancy.

REQ-018 Sub-module fetch_fifo SHALL be a DEPTH-parameterised synchronous FIFO of fetch_entry_t, with push, pop, flush, count, full and empty. It SHALL be built on the async active-low reset, and flush SHALL have priority over push.

REQ-019 All PC, credit and drop logic SHALL reside in fetch_queue_unit.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, imem_req_ready=1, one-cycle memory, inst_ready=1 -> addresses 0, 4, 8, ... issued; inst_pc sequence 0, 4, 8 with 1-cycle gaps after each response.
- inst_ready=0, DEPTH=4, MAX_OUT=2 -> exactly 4 handshakes, then imem_req_valid=0 and occupancy=4; one pop -> exactly one new request.
- Two requests outstanding (0x10, 0x14), then redirect_pc=0x100 -> both responses dropped; next inst_pc=0x100; occupancy 0 in the cycle after the redirect.
- imem_req_ready held low for 5 cycles while halt rises -> imem_req_addr stable, request completes, then no further requests.
- Response and redirect in the same cycle, MAX_OUT=2 with 2 in flight -> drop_cnt=1; next two responses yield only the second accepted at redirect_pc.
- Reset asserted with 2 in flight and queue full -> all outputs 0 immediately; after release, first request addr=RESET_PC.
